// File: rtl/btb_next_pc_pkg.sv
// Shared IF-stage definitions: instruction size, reset PC, predictor state
// encodings and the BTB entry layout for the default geometry.
package btb_next_pc_pkg;

    localparam int unsigned INSTR_BYTES         = 4;
    localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
    localparam int unsigned XLEN_DEFAULT        = 32;
    localparam int unsigned BTB_ENTRIES_DEFAULT = 16;
    localparam int unsigned BTB_TAG_W_DEFAULT   =
        XLEN_DEFAULT - $clog2(BTB_ENTRIES_DEFAULT) - 2;

    // Encodings of the 2-bit saturating predictor that consumes `branch`.
    typedef enum logic [1:0] {
        PRED_STRONG_NT = 2'b00,
        PRED_WEAK_NT   = 2'b01,
        PRED_WEAK_T    = 2'b10,
        PRED_STRONG_T  = 2'b11
    } pred_state_e;

    typedef struct packed {
        logic                         valid;
        logic [BTB_TAG_W_DEFAULT-1:0] tag;
        logic [XLEN_DEFAULT-1:0]      target;
    } btb_entry_t;

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: async-cleared valid bits, one combinational read
// port (old contents on same-cycle write) and one synchronous write port.
module btb_table
    import btb_next_pc_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEFAULT,
    parameter int unsigned BTB_ENTRIES = BTB_ENTRIES_DEFAULT,
    parameter int unsigned IDXW        = $clog2(BTB_ENTRIES),
    parameter int unsigned TAGW        = XLEN - IDXW - 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IDXW-1:0] rd_idx_i,
    input  logic [TAGW-1:0] rd_tag_i,
    output logic            rd_hit_o,
    output logic [XLEN-1:0] rd_target_o,
    input  logic            wr_en_i,
    input  logic [IDXW-1:0] wr_idx_i,
    input  logic [TAGW-1:0] wr_tag_i,
    input  logic [XLEN-1:0] wr_target_i
);

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]        tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_q [BTB_ENTRIES];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; that is also what makes a same-cycle lookup
    // see the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // NOTE: only the valid bits are reset; tag/target arrays stay plain RAM
    // because a cleared valid bit already masks whatever they hold.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
        end
    end

    assign rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_target_o = rd_hit_o ? target_q[rd_idx_i] : '0;

endmodule

// File: rtl/btb_next_pc.sv
// IF-stage next-PC generator: fetch PC register, BTB lookup and next-PC mux.
// Optional hit/redirect counters are enabled by defining BTB_STATS_EN.
module btb_next_pc
    import btb_next_pc_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEFAULT,
    parameter int unsigned BTB_ENTRIES = BTB_ENTRIES_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_if,
    input  logic            predict_taken,
    input  logic            ex_branch,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic            branch,
    output logic [XLEN-1:0] pred_target,
    output logic            pred_taken_pc
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]     stat_hits,
    output logic [31:0]     stat_redirects
`endif
);

    localparam int unsigned IDXW = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = XLEN - IDXW - 2;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            hit;
    logic [XLEN-1:0] hit_target;
    logic            take_pred;

    // Byte offset within a word never reaches the BTB.
    logic [1:0] unused_ex_pc_lsbs;
    assign unused_ex_pc_lsbs = ex_pc[1:0];

    btb_table #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb_table (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (pc_q[IDXW+1:2]),
        .rd_tag_i    (pc_q[XLEN-1:IDXW+2]),
        .rd_hit_o    (hit),
        .rd_target_o (hit_target),
        .wr_en_i     (ex_branch && ex_taken),
        .wr_idx_i    (ex_pc[IDXW+1:2]),
        .wr_tag_i    (ex_pc[XLEN-1:IDXW+2]),
        .wr_target_i (ex_target)
    );

    assign take_pred = !ex_redirect && !stall_if && hit && predict_taken;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pc_d = pc_q + XLEN'(INSTR_BYTES);
        if (ex_redirect) begin
            pc_d = ex_redirect_pc;
        end else if (stall_if) begin
            pc_d = pc_q;
        end else if (take_pred) begin
            pc_d = hit_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc            = pc_q;
    assign branch        = hit;
    assign pred_target   = hit_target;
    assign pred_taken_pc = take_pred;

`ifdef BTB_STATS_EN
    logic [31:0] stat_hits_q, stat_redirects_q;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits_q      <= '0;
            stat_redirects_q <= '0;
        end else begin
            if (hit && !stall_if && (stat_hits_q != '1)) begin
                stat_hits_q <= stat_hits_q + 32'd1;
            end
            if (ex_redirect && (stat_redirects_q != '1)) begin
                stat_redirects_q <= stat_redirects_q + 32'd1;
            end
        end
    end

    assign stat_hits      = stat_hits_q;
    assign stat_redirects = stat_redirects_q;
`endif

endmodule

// File: tb/tb_btb_next_pc.sv
// Directed self-checking bench for btb_next_pc (BTB_ENTRIES=16, RESET_PC=0).
module tb_btb_next_pc;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_if;
    logic        predict_taken;
    logic        ex_branch;
    logic        ex_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_redirect;
    logic [31:0] ex_redirect_pc;
    logic [31:0] pc;
    logic        branch;
    logic [31:0] pred_target;
    logic        pred_taken_pc;
`ifdef BTB_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_redirects;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    btb_next_pc #(
        .XLEN        (32),
        .BTB_ENTRIES (16),
        .RESET_PC    (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_if       (stall_if),
        .predict_taken  (predict_taken),
        .ex_branch      (ex_branch),
        .ex_taken       (ex_taken),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_redirect    (ex_redirect),
        .ex_redirect_pc (ex_redirect_pc),
        .pc             (pc),
        .branch         (branch),
        .pred_target    (pred_target),
        .pred_taken_pc  (pred_taken_pc)
`ifdef BTB_STATS_EN
        ,
        .stat_hits      (stat_hits),
        .stat_redirects (stat_redirects)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_if       = 1'b0;
        predict_taken  = 1'b0;
        ex_branch      = 1'b0;
        ex_taken       = 1'b0;
        ex_pc          = '0;
        ex_target      = '0;
        ex_redirect    = 1'b0;
        ex_redirect_pc = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        check("reset_pc", pc, 32'h0);
        check("reset_branch", branch, 1'b0);
        rst = 1'b0;
        #1;

        // Sequential fetch after reset release.
        check("seq_pc0", pc, 32'h0);
        tick(); check("seq_pc4", pc, 32'h4);
        check("seq_branch", branch, 1'b0);
        tick(); check("seq_pc8", pc, 32'h8);
        tick(); check("seq_pc12", pc, 32'hC);

        // Install 0x40 -> 0x100 and redirect to 0x40 in the same cycle.
        ex_branch = 1'b1; ex_taken = 1'b1; ex_pc = 32'h40; ex_target = 32'h100;
        ex_redirect = 1'b1; ex_redirect_pc = 32'h40;
        tick();
        idle_inputs();
        predict_taken = 1'b1;
        #1;
        check("hit_pc", pc, 32'h40);
        check("hit_branch", branch, 1'b1);
        check("hit_target", pred_target, 32'h100);
        check("hit_pred_taken_pc", pred_taken_pc, 1'b1);
        tick();
        check("pred_next_pc", pc, 32'h100);

        // Same hit, predictor says not-taken; a not-taken resolution must not
        // disturb the entry.
        ex_redirect = 1'b1; ex_redirect_pc = 32'h40;
        ex_branch = 1'b1; ex_taken = 1'b0; ex_pc = 32'h40; ex_target = 32'h500;
        tick();
        idle_inputs();
        #1;
        check("nt_branch", branch, 1'b1);
        check("nt_target_kept", pred_target, 32'h100);
        check("nt_pred_taken_pc", pred_taken_pc, 1'b0);
        tick();
        check("nt_next_pc", pc, 32'h44);

        // Redirect wins over stall; then stall holds pc for three cycles while
        // a BTB write for aliasing address 0x440 still lands.
        ex_redirect = 1'b1; ex_redirect_pc = 32'h200; stall_if = 1'b1;
        tick();
        check("redirect_over_stall", pc, 32'h200);
        idle_inputs();
        stall_if = 1'b1;
        ex_branch = 1'b1; ex_taken = 1'b1; ex_pc = 32'h440; ex_target = 32'h300;
        tick();
        ex_branch = 1'b0; ex_taken = 1'b0;
        check("stall_hold1", pc, 32'h200);
        tick(); check("stall_hold2", pc, 32'h200);
        tick(); check("stall_hold3", pc, 32'h200);
        check("stall_pred_taken_pc", pred_taken_pc, 1'b0);

        // Aliasing: 0x40 and 0x440 share index 0; 0x440 now owns it.
        idle_inputs();
        ex_redirect = 1'b1; ex_redirect_pc = 32'h40;
        tick();
        idle_inputs();
        predict_taken = 1'b1;
        #1;
        check("alias_old_miss", branch, 1'b0);
        check("alias_old_target", pred_target, 32'h0);
        ex_redirect = 1'b1; ex_redirect_pc = 32'h440;
        tick();
        ex_redirect = 1'b0;
        #1;
        check("alias_new_branch", branch, 1'b1);
        check("alias_new_target", pred_target, 32'h300);
        tick();
        check("alias_next_pc", pc, 32'h300);

        // PC wrap at the top of the address space.
        idle_inputs();
        ex_redirect = 1'b1; ex_redirect_pc = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        tick();
        check("wrap_pc", pc, 32'h0);

        // Write and lookup at 0x80 in the same cycle: old contents seen.
        ex_redirect = 1'b1; ex_redirect_pc = 32'h80;
        tick();
        idle_inputs();
        predict_taken = 1'b1;
        ex_branch = 1'b1; ex_taken = 1'b1; ex_pc = 32'h80; ex_target = 32'h600;
        ex_redirect = 1'b1; ex_redirect_pc = 32'h80;
        #1;
        check("same_cycle_miss", branch, 1'b0);
        tick();
        idle_inputs();
        #1;
        check("after_write_pc", pc, 32'h80);
        check("after_write_branch", branch, 1'b1);
        check("after_write_target", pred_target, 32'h600);

        // Asynchronous reset mid-cycle clears pc and every entry at once.
        rst = 1'b1;
        #1;
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_branch", branch, 1'b0);
`ifdef BTB_STATS_EN
        check("rst_stat_hits", stat_hits, 32'h0);
        check("rst_stat_redirects", stat_redirects, 32'h0);
`endif
        tick();
        rst = 1'b0;
        ex_redirect = 1'b1; ex_redirect_pc = 32'h80;
        tick();
        idle_inputs();
        #1;
        check("post_rst_pc", pc, 32'h80);
        check("post_rst_miss", branch, 1'b0);
        check("post_rst_target", pred_target, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btb_next_pc.md
Name: btb_next_pc

Overview:
- IF-stage next-PC generator. Holds the fetch PC register and a direct-mapped branch target buffer (BTB).
- Drives `branch` into the 2-bit branch predictor and consumes `branch_prediction` from it.
- Selects the next fetch PC from four sources: EX redirect, stall hold, predicted target, or sequential PC+4.
- BTB entries are written from EX branch resolution.

Parameters:
- XLEN, 32, PC/address width.
- BTB_ENTRIES, 16, number of BTB entries. Must be a power of 2, at least 2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- stall_if  in  1  hold PC (hazard/fetch stall)
- predict_taken  in  1  branch_prediction from the 2-bit predictor
- ex_branch  in  1  EX resolving a branch this cycle
- ex_taken  in  1  resolved direction
- ex_pc  in  XLEN  PC of resolving branch
- ex_target  in  XLEN  resolved target
- ex_redirect  in  1  EX mispredict; force fetch to ex_redirect_pc
- ex_redirect_pc  in  XLEN  correct next PC
- pc  out  XLEN  current fetch PC (registered)
- branch  out  1  current pc hits in BTB; drives the predictor's `branch`
- pred_target  out  XLEN  BTB target for pc (0 on miss)
- pred_taken_pc  out  1  next PC came from the BTB target

Behaviour:
- Address fields: IDXW = log2(BTB_ENTRIES). idx = pc[IDXW+1:2]. tag = pc[XLEN-1:IDXW+2]. pc[1:0] is ignored.
- Each entry holds valid, tag and target. On reset all valid bits clear and pc = RESET_PC.
- Lookup is combinational on the current pc:
  - hit = valid[idx] && tag matches.
  - branch = hit; pred_target = hit ? target : 0.
- next_pc priority (highest first):
  1. ex_redirect -> ex_redirect_pc.
  2. stall_if -> pc (hold).
  3. hit && predict_taken -> target.
  4. otherwise pc + 4, wrapping modulo 2^XLEN.
- pred_taken_pc = 1 only when rule 3 is selected.
- pc updates to next_pc on every clk rising edge. Redirect-to-fetch latency is 1 cycle.
- ex_redirect overrides stall_if in the same cycle.
- BTB write occurs on the rising edge when ex_branch && ex_taken:
  - entry[ex_pc idx] <= {1, ex_pc tag, ex_target}.
  - Any existing entry at that index is overwritten, including one with a different tag.
- ex_branch && !ex_taken: no BTB change. Direction is left to the predictor.
- Simultaneous write and lookup at the same index: the lookup sees the old contents. The new entry becomes visible the next cycle.
- Write while stall_if is high: the write still occurs.
- Reset asserted mid-operation:
  - pc = RESET_PC and all entries are invalidated immediately (asynchronous).
  - Outputs reflect a miss until the first write after reset deasserts.
- There is no handshake; every input is sampled every cycle.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined:
  - Adds outputs stat_hits (32) and stat_redirects (32).
  - stat_hits increments each cycle that branch=1 && !stall_if.
  - stat_redirects increments each cycle that ex_redirect=1.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: no counters and no ports; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - Constant INSTR_BYTES = 4.
  - RESET_PC default.
  - Predictor state encodings, already used by the predictor.
  - A typedef for the BTB entry {valid, tag, target}.
- One sub-module, btb_table:
  - Storage, valid bits and async clear.
  - Combinational read port: idx/tag in, hit/target out.
  - Single write port.
- btb_next_pc keeps the PC register, next-PC mux and stats.

Test Plan:
1. Reset, then release with no other stimulus -> pc = 0, then 4, 8, 12 on successive edges; branch = 0 throughout.
2. ex_branch=1, ex_taken=1, ex_pc=0x40, ex_target=0x100; later pc reaches 0x40 with predict_taken=1 -> branch=1, pred_target=0x100, next pc=0x100, pred_taken_pc=1. Repeat with predict_taken=0 -> next pc=0x44.
3. ex_redirect=1, ex_redirect_pc=0x200 with stall_if=1 in the same cycle -> pc=0x200 next edge. stall_if alone for 3 cycles -> pc held.
4. Aliasing with BTB_ENTRIES=16: write for 0x40, then 0x440 taken to 0x300 -> lookup at 0x40 misses (tag mismatch); lookup at 0x440 gives 0x300.
5. Write to 0x80 in the same cycle pc=0x80 -> branch=0 that cycle. After redirect back to 0x80 -> branch=1.
6. Assert rst mid-run after entries are written -> pc=RESET_PC immediately and all lookups miss. With BTB_STATS_EN, counters read 0.
